// File: rtl/vga_axil_pkg.sv
// Shared AXI4-Lite types and helpers for the VGA control register file.
package vga_axil_pkg;

   localparam int AXIL_ADDR_MAX = 32;
   localparam int AXIL_DATA_MAX = 64;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } axil_resp_e;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } axil_rd_state_e;

   typedef logic [AXIL_ADDR_MAX-1:0] axil_addr_t;
   typedef logic [AXIL_DATA_MAX-1:0] axil_data_t;

   // Word index of a byte address; byte-offset bits are dropped.
   function automatic axil_addr_t axil_word_index(input axil_addr_t addr, input int data_width);
      return (data_width == 64) ? (addr >> 3) : (addr >> 2);
   endfunction

endpackage

// File: rtl/vga_axil_wr_collector.sv
// AXI4-Lite write side: one-entry AW and W buffers, commit decode and B response.
// Byte strobes exist only when VGA_AXIL_REGFILE_WSTRB_EN is defined.
module vga_axil_wr_collector
   import vga_axil_pkg::*;
#(
   parameter int                   ADDR_WIDTH = 8,
   parameter int                   DATA_WIDTH = 32,
   parameter int                   REG_COUNT  = 8,
   parameter logic [REG_COUNT-1:0] RO_MASK    = '0
) (
   input  logic                    clk,
   input  logic                    arst,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
   input  logic [DATA_WIDTH/8-1:0] wstrb,
`endif
   input  logic                    wvalid,
   output logic                    wready,
   output axil_resp_e              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   output logic                    wr_en,
   output axil_addr_t              wr_index,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic [DATA_WIDTH/8-1:0] wr_be
);

   logic [ADDR_WIDTH-1:0]   aw_addr_q;
   logic [DATA_WIDTH-1:0]   w_data_q;
   logic [DATA_WIDTH/8-1:0] w_strb_q;
   logic [DATA_WIDTH/8-1:0] strb_in;
   logic [ADDR_WIDTH-1:0]   addr_sel;
   logic                    aw_go, w_go, commit, writable;

`ifdef VGA_AXIL_REGFILE_WSTRB_EN
   assign strb_in = wstrb;
`else
   assign strb_in = '1;
`endif

   assign aw_go = awvalid & awready;
   assign w_go  = wvalid & wready;

   // A handshake on the commit edge is forwarded straight into the commit, so
   // bvalid rises one cycle after the later of the two handshakes.
   assign commit   = (aw_go | ~awready) & (w_go | ~wready) & ~bvalid;
   assign addr_sel = awready ? awaddr  : aw_addr_q;
   assign wr_data  = wready  ? wdata   : w_data_q;
   assign wr_be    = wready  ? strb_in : w_strb_q;
   assign wr_index = axil_word_index(axil_addr_t'(addr_sel), DATA_WIDTH);
   assign wr_en    = commit & writable;

   always_comb begin
      // NOTE: default before the loop so no path leaves writable unassigned (no latch).
      writable = 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
         if (wr_index == axil_addr_t'(i) && !RO_MASK[i]) writable = 1'b1;
      end
   end

   // NOTE: state updates use <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         awready   <= 1'b1;
         wready    <= 1'b1;
         bvalid    <= 1'b0;
         bresp     <= OKAY;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         if (aw_go) begin
            aw_addr_q <= awaddr;
            awready   <= 1'b0;
         end
         if (w_go) begin
            w_data_q <= wdata;
            w_strb_q <= strb_in;
            wready   <= 1'b0;
         end
         if (commit) begin
            bvalid <= 1'b1;
            bresp  <= writable ? OKAY : SLVERR;
         end else if (bvalid && bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_axil_regfile.sv
// Parametrised AXI4-Lite register file feeding the VGA timing/control logic.
// Define VGA_AXIL_REGFILE_WSTRB_EN to add the wstrb port and byte-masked writes.
module vga_axil_regfile
   import vga_axil_pkg::*;
#(
   parameter int                              ADDR_WIDTH  = 8,
   parameter int                              DATA_WIDTH  = 32,
   parameter int                              REG_COUNT   = 8,
   parameter logic [REG_COUNT-1:0]            RO_MASK     = '0,
   parameter logic [REG_COUNT*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                              clk,
   input  logic                              arst,
   input  logic [ADDR_WIDTH-1:0]             awaddr,
   input  logic                              awvalid,
   output logic                              awready,
   input  logic [DATA_WIDTH-1:0]             wdata,
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
   input  logic [DATA_WIDTH/8-1:0]           wstrb,
`endif
   input  logic                              wvalid,
   output logic                              wready,
   output axil_resp_e                        bresp,
   output logic                              bvalid,
   input  logic                              bready,
   input  logic [ADDR_WIDTH-1:0]             araddr,
   input  logic                              arvalid,
   output logic                              arready,
   output logic [DATA_WIDTH-1:0]             rdata,
   output axil_resp_e                        rresp,
   output logic                              rvalid,
   input  logic                              rready,
   input  logic [REG_COUNT*DATA_WIDTH-1:0]   status_i,
   output logic [REG_COUNT*DATA_WIDTH-1:0]   reg_o
);

   if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
      $error("vga_axil_regfile: DATA_WIDTH must be 32 or 64");
   end
   if (REG_COUNT < 1 || REG_COUNT > 2 ** (ADDR_WIDTH - $clog2(DATA_WIDTH / 8))) begin : g_bad_count
      $error("vga_axil_regfile: REG_COUNT out of range for ADDR_WIDTH");
   end

   logic                    wr_en;
   axil_addr_t              wr_index;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH/8-1:0] wr_be;
   axil_addr_t              rd_index;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    rd_hit;
   axil_rd_state_e          rd_state;
   logic                    status_unused;

   // Status slices behind RW registers are intentionally ignored.
   assign status_unused = ^status_i;

   vga_axil_wr_collector #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .REG_COUNT (REG_COUNT),
      .RO_MASK   (RO_MASK)
   ) u_wr (
      .clk     (clk),
      .arst    (arst),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
      .wstrb   (wstrb),
`endif
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready),
      .wr_en   (wr_en),
      .wr_index(wr_index),
      .wr_data (wr_data),
      .wr_be   (wr_be)
   );

   for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
      if (RO_MASK[i]) begin : g_ro
         assign reg_o[i*DATA_WIDTH +: DATA_WIDTH] = status_i[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_rw
         logic [DATA_WIDTH-1:0] q;
         // NOTE: these are control flops with defined power-up values, so each one is reset.
         always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
               q <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (wr_en && wr_index == axil_addr_t'(i)) begin
               for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                  if (wr_be[b]) q[b*8 +: 8] <= wr_data[b*8 +: 8];
               end
            end
         end
         assign reg_o[i*DATA_WIDTH +: DATA_WIDTH] = q;
      end
   end

   assign rd_index = axil_word_index(axil_addr_t'(araddr), DATA_WIDTH);

   always_comb begin
      rd_word = '0;
      rd_hit  = 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
         if (rd_index == axil_addr_t'(i)) begin
            rd_word = reg_o[i*DATA_WIDTH +: DATA_WIDTH];
            rd_hit  = 1'b1;
         end
      end
   end

   // Registers sample pre-edge contents, so a read racing a commit returns the old value.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rd_state <= R_IDLE;
         arready  <= 1'b1;
         rvalid   <= 1'b0;
         rdata    <= '0;
         rresp    <= OKAY;
      end else begin
         case (rd_state)
            R_IDLE: if (arvalid) begin
               rd_state <= R_RESP;
               arready  <= 1'b0;
               rvalid   <= 1'b1;
               rdata    <= rd_word;
               rresp    <= rd_hit ? OKAY : SLVERR;
            end
            R_RESP: if (rready) begin
               rd_state <= R_IDLE;
               arready  <= 1'b1;
               rvalid   <= 1'b0;
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_axil_regfile.sv
// Self-checking bench for vga_axil_regfile: directed vector table, hand-written
// corner sequences and randomized traffic against a word-array reference model.
module tb_vga_axil_regfile;
   import vga_axil_pkg::*;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int RC = 8;
   localparam logic [RC-1:0]    RO = 8'h02;
   localparam logic [RC*DW-1:0] RV = {32'h7777_7007, 32'h6666_6006, 32'h5555_5005, 32'h4444_4004,
                                      32'h3333_3003, 32'h2222_2002, 32'hBAD0_0001, 32'h0A0A_0A0A};

   logic            clk = 1'b0;
   logic            arst;
   logic [AW-1:0]   awaddr, araddr;
   logic            awvalid, wvalid, bready, arvalid, rready;
   logic [DW-1:0]   wdata;
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
   logic [DW/8-1:0] wstrb;
`endif
   logic            awready, wready, bvalid, arready, rvalid;
   axil_resp_e      bresp, rresp;
   logic [DW-1:0]   rdata;
   logic [RC*DW-1:0] status_i, reg_o;

   int tests = 0;
   int fails = 0;
   logic [DW-1:0] mdl [RC];

   always #5 clk = ~clk;

   vga_axil_regfile #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_COUNT(RC), .RO_MASK(RO), .RESET_VALUE(RV)
   ) dut (
      .clk(clk), .arst(arst),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata),
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
      .wstrb(wstrb),
`endif
      .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .status_i(status_i), .reg_o(reg_o)
   );

   typedef struct {
      bit            is_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            gap;   // edges from AW handshake to W handshake (negative: W first)
      axil_resp_e    resp;
      logic [DW-1:0] rd;
   } vec_t;

   task automatic check(input string name, input logic [RC*DW-1:0] act, input logic [RC*DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      check(name, {{(RC*DW-32){1'b0}}, act}, {{(RC*DW-32){1'b0}}, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a plain array of words plus the read-only/out-of-range rules.
   task automatic model_reset();
      for (int i = 0; i < RC; i++) mdl[i] = RV[i*DW +: DW];
   endtask

   function automatic axil_resp_e model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                              input logic [DW/8-1:0] strb);
      int idx = int'(addr) / (DW / 8);
      if (idx >= RC || RO[idx]) return SLVERR;
      for (int b = 0; b < DW / 8; b++) if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
      return OKAY;
   endfunction

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr, output axil_resp_e resp);
      int idx = int'(addr) / (DW / 8);
      resp = OKAY;
      if (idx >= RC) begin
         resp = SLVERR;
         return '0;
      end
      return RO[idx] ? status_i[idx*DW +: DW] : mdl[idx];
   endfunction

   function automatic logic [RC*DW-1:0] model_regs();
      logic [RC*DW-1:0] v;
      for (int i = 0; i < RC; i++) v[i*DW +: DW] = RO[i] ? status_i[i*DW +: DW] : mdl[i];
      return v;
   endfunction

   task automatic b_accept();
      bready = 1'b1;
      tick();
      bready = 1'b0;
   endtask

   task automatic r_accept();
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   task automatic axil_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int gap,
                             input bit hold_b, output axil_resp_e resp, output int lat);
      int n = 0;
      while (!(awready && wready) && n < 100) begin tick(); n++; end
      check32("write_idle_ready", 32'(awready & wready), 32'd1);
      awaddr = addr;
      wdata  = data;
      if (gap >= 0) begin
         awvalid = 1'b1;
         wvalid  = (gap == 0);
         tick();
         awvalid = 1'b0;
         wvalid  = 1'b0;
         if (gap > 0) begin
            repeat (gap - 1) tick();
            check32("no_early_bvalid", 32'(bvalid), 32'd0);
            wvalid = 1'b1;
            tick();
            wvalid = 1'b0;
         end
      end else begin
         wvalid = 1'b1;
         tick();
         wvalid = 1'b0;
         repeat (-gap - 1) tick();
         check32("no_early_bvalid", 32'(bvalid), 32'd0);
         awvalid = 1'b1;
         tick();
         awvalid = 1'b0;
      end
      lat = 1;
      while (!bvalid && lat < 50) begin tick(); lat++; end
      resp = bresp;
      if (!hold_b) b_accept();
   endtask

   task automatic axil_read(input logic [AW-1:0] addr, input bit hold_r, output logic [DW-1:0] data,
                            output axil_resp_e resp, output int lat);
      int n = 0;
      while (!arready && n < 100) begin tick(); n++; end
      check32("read_idle_ready", 32'(arready), 32'd1);
      araddr  = addr;
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < 50) begin tick(); lat++; end
      data = rdata;
      resp = rresp;
      if (!hold_r) r_accept();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t          vecs [8];
      axil_resp_e    resp, exp_resp;
      logic [DW-1:0] data, exp_data;
      logic [DW/8-1:0] strb;
      int            lat, bad;

      vecs[0] = '{1'b1, 8'h08, 32'hDEAD_BEEF, 3,  OKAY,   32'h0};
      vecs[1] = '{1'b0, 8'h08, 32'h0,         0,  OKAY,   32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 8'h04, 32'h5555_5555, -2, SLVERR, 32'h0};
      vecs[3] = '{1'b0, 8'h04, 32'h0,         0,  OKAY,   32'h0000_1234};
      vecs[4] = '{1'b1, 8'h40, 32'h1111_1111, 0,  SLVERR, 32'h0};
      vecs[5] = '{1'b0, 8'h40, 32'h0,         0,  SLVERR, 32'h0};
      vecs[6] = '{1'b1, 8'h1F, 32'hCAFE_F00D, 1,  OKAY,   32'h0};
      vecs[7] = '{1'b0, 8'h1C, 32'h0,         0,  OKAY,   32'hCAFE_F00D};

      arst = 1'b1;
      awaddr = '0; araddr = '0; wdata = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
      wstrb = '1;
`endif
      for (int i = 0; i < RC; i++) status_i[i*DW +: DW] = $urandom;
      status_i[1*DW +: DW] = 32'h0000_1234;
      strb = '1;
      model_reset();
      repeat (3) tick();
      arst = 1'b0;
      tick();

      // Reset state
      check32("rst_ready", 32'({awready, wready, arready}), 32'h7);
      check32("rst_valid", 32'({bvalid, rvalid}), 32'h0);
      check32("rst_resp", 32'({bresp, rresp}), 32'h0);
      check32("rst_rdata", rdata, 32'h0);
      check("rst_reg_o", reg_o, model_regs());

      for (int i = 0; i < RC; i++) begin
         axil_read(AW'(i * 4), 1'b0, data, resp, lat);
         exp_data = model_read(AW'(i * 4), exp_resp);
         check32($sformatf("rst_read_%0d", i), data, exp_data);
         check32($sformatf("rst_rresp_%0d", i), 32'(resp), 32'(exp_resp));
         check32($sformatf("rst_rlat_%0d", i), 32'(lat), 32'd1);
      end

      // Directed vector table
      for (int v = 0; v < 8; v++) begin
         if (vecs[v].is_wr) begin
            axil_write(vecs[v].addr, vecs[v].data, vecs[v].gap, 1'b0, resp, lat);
            void'(model_write(vecs[v].addr, vecs[v].data, strb));
            check32($sformatf("vec%0d_bresp", v), 32'(resp), 32'(vecs[v].resp));
            check32($sformatf("vec%0d_blat", v), 32'(lat), 32'd1);
            check($sformatf("vec%0d_reg_o", v), reg_o, model_regs());
         end else begin
            axil_read(vecs[v].addr, 1'b0, data, resp, lat);
            check32($sformatf("vec%0d_rdata", v), data, vecs[v].rd);
            check32($sformatf("vec%0d_rresp", v), 32'(resp), 32'(vecs[v].resp));
            check32($sformatf("vec%0d_rlat", v), 32'(lat), 32'd1);
         end
      end

      // B back-pressure: a read completes while the write response is held
      axil_write(8'h0C, 32'h0BAD_F00D, 0, 1'b1, resp, lat);
      void'(model_write(8'h0C, 32'h0BAD_F00D, strb));
      check32("bp_bresp", 32'(resp), 32'(OKAY));
      axil_read(8'h00, 1'b0, data, resp, lat);
      check32("bp_rdata", data, mdl[0]);
      check32("bp_rlat", 32'(lat), 32'd1);
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         if (!bvalid || awready || wready || bresp != OKAY) bad++;
         tick();
      end
      check32("bp_b_held", 32'(bad), 32'd0);
      b_accept();
      check32("bp_after_b", 32'({bvalid, awready, wready}), 32'h3);
      check("bp_reg_o", reg_o, model_regs());

      // Commit and AR on the same register in the same cycle: read sees the old value
      exp_data = mdl[3];
      awaddr = 8'h0C; araddr = 8'h0C; wdata = 32'h1357_9BDF;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      void'(model_write(8'h0C, 32'h1357_9BDF, strb));
      check32("race_valids", 32'({bvalid, rvalid}), 32'h3);
      check32("race_rdata_old", rdata, exp_data);
      check32("race_bresp", 32'(bresp), 32'(OKAY));
      check("race_reg_o", reg_o, model_regs());
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      check32("race_done", 32'({bvalid, rvalid, awready, arready}), 32'h3);

      // Asynchronous reset with both responses pending
      axil_write(8'h00, 32'hFFFF_0000, 0, 1'b1, resp, lat);
      axil_read(8'h08, 1'b1, data, resp, lat);
      check32("arst_pending", 32'({bvalid, rvalid}), 32'h3);
      #1 arst = 1'b1;
      #1;
      model_reset();
      check32("arst_valids", 32'({bvalid, rvalid}), 32'h0);
      check32("arst_ready", 32'({awready, wready, arready}), 32'h7);
      check32("arst_rdata", rdata, 32'h0);
      check("arst_reg_o", reg_o, model_regs());
      #2 arst = 1'b0;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bvalid || rvalid) bad++;
      end
      check32("arst_no_stale_resp", 32'(bad), 32'd0);
      axil_read(8'h00, 1'b0, data, resp, lat);
      check32("arst_read0", data, RV[31:0]);

`ifdef VGA_AXIL_REGFILE_WSTRB_EN
      // Byte strobes
      wstrb = 4'hF;
      axil_write(8'h00, 32'h0, 0, 1'b0, resp, lat);
      void'(model_write(8'h00, 32'h0, 4'hF));
      wstrb = 4'b0101;
      axil_write(8'h00, 32'hAABB_CCDD, 0, 1'b0, resp, lat);
      void'(model_write(8'h00, 32'hAABB_CCDD, 4'b0101));
      check32("strb_bresp", 32'(resp), 32'(OKAY));
      check32("strb_reg0", reg_o[31:0], 32'h00BB_00DD);
      wstrb = 4'b0000;
      axil_write(8'h00, 32'h1234_5678, 0, 1'b0, resp, lat);
      check32("strb0_bresp", 32'(resp), 32'(OKAY));
      check32("strb0_reg0", reg_o[31:0], 32'h00BB_00DD);
`endif

      // Randomized traffic against the model
      for (int t = 0; t < 150; t++) begin
         logic [AW-1:0] addr;
         logic [DW-1:0] wd;
         int            gap;
         addr = AW'($urandom_range(0, 8'h4F));
         wd   = $urandom;
         gap  = $urandom_range(0, 6) - 3;
         status_i[1*DW +: DW] = $urandom;
         status_i[5*DW +: DW] = $urandom;
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
         strb  = DW'($urandom) % 16;
         wstrb = strb;
`endif
         if ($urandom_range(0, 1) == 1) begin
            axil_write(addr, wd, gap, 1'b0, resp, lat);
            exp_resp = model_write(addr, wd, strb);
            check32($sformatf("rnd%0d_bresp", t), 32'(resp), 32'(exp_resp));
            check32($sformatf("rnd%0d_blat", t), 32'(lat), 32'd1);
         end else begin
            axil_read(addr, 1'b0, data, resp, lat);
            exp_data = model_read(addr, exp_resp);
            check32($sformatf("rnd%0d_rdata", t), data, exp_data);
            check32($sformatf("rnd%0d_rresp", t), 32'(resp), 32'(exp_resp));
         end
         check($sformatf("rnd%0d_reg_o", t), reg_o, model_regs());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
